// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
//
// Sits between decode and execute. Keeps one busy bit per architectural
// register for every in-flight instruction that will write back, stalls
// decode on RAW/WAW hazards against those pending writes, and sequences
// fence-style drains (RUN -> DRAIN -> DONE -> RUN). A saturating counter
// records the number of stalled cycles.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), async active-high reset
//   id_valid_i              decode holds a valid instruction
//   id_rs1_i/id_rs2_i/id_rd_i   register addresses of that instruction
//   id_uses_rs1_i/id_uses_rs2_i whether rs1/rs2 are actually read
//   id_regwrite_i           instruction writes rd
//   wb_valid_i, wb_rd_i     writeback to the register file this cycle
//   flush_i                 pipeline squash, clears every busy bit
//   drain_req_i             fence request (level, sampled only in RUN)
//   issue_o                 instruction advances to execute this cycle
//   stall_o                 hold fetch/decode
//   drain_done_o            one-cycle pulse when a drain completes
//   busy_o                  busy vector, bit 0 always 0
//   outstanding_o           registered popcount of busy_o
//   stall_cnt_o             saturating count of stalled cycles
// ---------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int NREGS     = 32,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_regwrite_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             flush_i,
    input  logic             drain_req_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             drain_done_o,
    output logic [NREGS-1:0] busy_o,
    output logic [5:0]       outstanding_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [5:0]       outstanding_q, outstanding_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NREGS-1:0] wb_clr;
    logic [NREGS-1:0] issue_set;
    logic [NREGS-1:0] eb;
    logic [NREGS-1:0] busy_after_clr;
    logic             hazard;

    // Writeback clear mask and the busy view the hazard check sees. With
    // the bypass enabled the register file is write-through, so a register
    // being written back this cycle is already safe to read.
    always_comb begin
        wb_clr = '0;
        if (wb_valid_i) begin
            wb_clr[wb_rd_i] = 1'b1;
        end
        busy_after_clr = busy_q & ~wb_clr;
        if (WB_BYPASS != 0) begin
            eb = busy_after_clr;
        end else begin
            eb = busy_q;
        end
        eb[0] = 1'b0;
    end

    // RAW on either source, or WAW on the destination.
    always_comb begin
        hazard = id_valid_i & ((id_uses_rs1_i & eb[id_rs1_i]) |
                               (id_uses_rs2_i & eb[id_rs2_i]) |
                               (id_regwrite_i & eb[id_rd_i]));
    end

    // Issue/stall/drain outputs. They are forced low while reset is held so
    // that an asynchronous reset quiets the pipeline without a clock edge.
    always_comb begin
        issue_o      = 1'b0;
        stall_o      = 1'b0;
        drain_done_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue_o = id_valid_i & ~hazard & ~flush_i & ~drain_req_i;
                stall_o = id_valid_i & (hazard | drain_req_i) & ~flush_i;
            end
            ST_DRAIN: begin
                stall_o = id_valid_i & ~flush_i;
            end
            ST_DONE: begin
                stall_o      = id_valid_i & ~flush_i;
                drain_done_o = 1'b1;
            end
            default: begin
                issue_o = 1'b0;
            end
        endcase
        if (reset_i) begin
            issue_o      = 1'b0;
            stall_o      = 1'b0;
            drain_done_o = 1'b0;
        end
    end

    // Busy vector update: clear first, then set, so an issue to a register
    // whose older write lands in the same cycle leaves it busy.
    always_comb begin
        issue_set = '0;
        if (issue_o & id_regwrite_i & (id_rd_i != 5'd0)) begin
            issue_set[id_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end else begin
            busy_d = busy_after_clr | issue_set;
        end
        busy_d[0] = 1'b0;
    end

    // Drain sequencing. Completion looks at the vector after this cycle's
    // writeback clear, so the pulse follows the last clear by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (busy_after_clr == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (flush_i) begin
            state_d = ST_RUN;
        end
    end

    // Outstanding count tracks the next busy vector so it lines up with
    // busy_o once registered.
    always_comb begin
        outstanding_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            outstanding_d = outstanding_d + {5'd0, busy_d[i]};
        end
    end

    // Stall counter holds at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_RUN;
            busy_q        <= '0;
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign outstanding_o = outstanding_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule
